gps_ca_multi_tss: RTL and testbench

Parametrised, LLKI-gated, multi-channel GPS C/A-code generator for the CEP GPS target. NUM_CH independent Gold-code channels run in lockstep under a common chip strobe. Each channel emits the IS-GPS-200 C/A sequence for its selected PRN only after the correct key has been loaded through a word-serial key port. While the block is locked, every channel emits the code of a deterministically wrong PRN.

---
 rtl/gps_ca_multi_tss.sv | 176 +++++++++++++++++
 tb/tb_gps_ca_multi_tss.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_ca_multi_tss.sv
// Multi-channel GPS C/A Gold-code generator behind a word-serial key lock.
// While the key is not loaded, each channel runs the PRN given by sv_num ^ LOCK_MASK.
module gps_ca_multi_tss #(
  parameter int                     NUM_CH    = 4,
  parameter int                     KEY_WORDS = 2,
  parameter logic [64*KEY_WORDS-1:0] KEY      = '0,
  parameter logic [5:0]             LOCK_MASK = 6'h15
) (
  input  logic                  sys_clk_50,
  input  logic                  sync_rst_in,
  input  logic [63:0]           key_word,
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic                  key_clear,
  output logic [1:0]            key_status,
  input  logic [6*NUM_CH-1:0]   sv_num,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  chip_en,
  output logic [NUM_CH-1:0]     ca_chip,
  output logic                  chip_valid,
  output logic [9:0]            chip_idx,
  output logic                  epoch,
  output logic                  busy
);

  typedef enum logic [1:0] {
    K_LOCKED   = 2'b00,
    K_LOADING  = 2'b01,
    K_UNLOCKED = 2'b10,
    K_ERROR    = 2'b11
  } key_state_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } seq_state_t;

  localparam logic [2:0] KEY_LAST = 3'(KEY_WORDS - 1);
  localparam logic [9:0] LAST_CHIP = 10'd1022;

  key_state_t              key_state_q;
  logic [2:0]              key_cnt_q;
  logic [64*KEY_WORDS-1:0] key_buf_q, key_buf_d;
  logic                    key_accept;

  assign key_ready  = ((key_state_q == K_LOCKED) || (key_state_q == K_LOADING)) && !key_clear;
  assign key_accept = key_valid && key_ready;
  assign key_status = key_state_q;

  // Candidate buffer with the incoming word already in place, so the last word joins the compare.
  always_comb begin
    key_buf_d = key_buf_q;
    for (int w = 0; w < KEY_WORDS; w++) begin
      if (key_cnt_q == 3'(w)) key_buf_d[w*64 +: 64] = key_word;
    end
  end

  always_ff @(posedge sys_clk_50) begin
    if (sync_rst_in || key_clear) begin
      key_state_q <= K_LOCKED;
      key_cnt_q   <= '0;
      key_buf_q   <= '0;
    end else if (key_accept) begin
      key_buf_q <= key_buf_d;
      if (key_cnt_q == KEY_LAST) begin
        key_state_q <= (key_buf_d == KEY) ? K_UNLOCKED : K_ERROR;
      end else begin
        key_state_q <= K_LOADING;
        key_cnt_q   <= key_cnt_q + 3'd1;
      end
    end
  end

  // G2 phase-select taps {s1, s2}; zero marks a PRN outside 1..32.
  function automatic logic [7:0] g2_taps(input logic [5:0] prn);
    case (prn)
      6'd1:  g2_taps = 8'h26;  6'd2:  g2_taps = 8'h37;
      6'd3:  g2_taps = 8'h48;  6'd4:  g2_taps = 8'h59;
      6'd5:  g2_taps = 8'h19;  6'd6:  g2_taps = 8'h2A;
      6'd7:  g2_taps = 8'h18;  6'd8:  g2_taps = 8'h29;
      6'd9:  g2_taps = 8'h3A;  6'd10: g2_taps = 8'h23;
      6'd11: g2_taps = 8'h34;  6'd12: g2_taps = 8'h56;
      6'd13: g2_taps = 8'h67;  6'd14: g2_taps = 8'h78;
      6'd15: g2_taps = 8'h89;  6'd16: g2_taps = 8'h9A;
      6'd17: g2_taps = 8'h14;  6'd18: g2_taps = 8'h25;
      6'd19: g2_taps = 8'h36;  6'd20: g2_taps = 8'h47;
      6'd21: g2_taps = 8'h58;  6'd22: g2_taps = 8'h69;
      6'd23: g2_taps = 8'h13;  6'd24: g2_taps = 8'h46;
      6'd25: g2_taps = 8'h57;  6'd26: g2_taps = 8'h68;
      6'd27: g2_taps = 8'h79;  6'd28: g2_taps = 8'h8A;
      6'd29: g2_taps = 8'h16;  6'd30: g2_taps = 8'h27;
      6'd31: g2_taps = 8'h38;  6'd32: g2_taps = 8'h49;
      default: g2_taps = 8'h00;
    endcase
  endfunction

  seq_state_t          seq_q;
  logic [6*NUM_CH-1:0] prn_q, prn_eff;
  logic [10:1]         g1_q, g2_q;
  logic [9:0]          cnt_q;
  logic [NUM_CH-1:0]   chip_d, ca_q;
  logic                valid_q, epoch_q;
  logic [9:0]          idx_q;
  logic                g1_fb, g2_fb;

  assign prn_eff = (key_state_q == K_UNLOCKED) ? sv_num : (sv_num ^ {NUM_CH{LOCK_MASK}});
  assign g1_fb   = g1_q[3] ^ g1_q[10];
  assign g2_fb   = g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [7:0]  taps;
      logic [10:1] sel;
      always_comb begin
        taps = g2_taps(prn_q[6*gi +: 6]);
        sel  = '0;
        for (int b = 1; b <= 10; b++) begin
          sel[b] = (taps[7:4] == 4'(b)) || (taps[3:0] == 4'(b));
        end
      end
      assign chip_d[gi] = (taps != 8'h00) && (g1_q[10] ^ (^(g2_q & sel)));
    end
  endgenerate

  always_ff @(posedge sys_clk_50) begin
    if (sync_rst_in) begin
      seq_q   <= S_IDLE;
      prn_q   <= '0;
      g1_q    <= '1;
      g2_q    <= '1;
      cnt_q   <= '0;
      ca_q    <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      epoch_q <= 1'b0;
    end else if (stop) begin
      seq_q   <= S_IDLE;
      valid_q <= 1'b0;
      epoch_q <= 1'b0;
    end else if (start) begin
      seq_q   <= S_RUN;
      prn_q   <= prn_eff;
      g1_q    <= '1;
      g2_q    <= '1;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      epoch_q <= 1'b0;
    end else if (seq_q == S_RUN && chip_en) begin
      ca_q    <= chip_d;
      idx_q   <= cnt_q;
      epoch_q <= (cnt_q == LAST_CHIP);
      valid_q <= 1'b1;
      // The code period is 1023 chips; restart both registers rather than let them run on.
      if (cnt_q == LAST_CHIP) begin
        g1_q  <= '1;
        g2_q  <= '1;
        cnt_q <= '0;
      end else begin
        g1_q  <= {g1_q[9:1], g1_fb};
        g2_q  <= {g2_q[9:1], g2_fb};
        cnt_q <= cnt_q + 10'd1;
      end
    end else begin
      valid_q <= 1'b0;
      epoch_q <= 1'b0;
    end
  end

  assign ca_chip    = ca_q;
  assign chip_valid = valid_q;
  assign chip_idx   = idx_q;
  assign epoch      = epoch_q;
  assign busy       = (seq_q == S_RUN);

endmodule

// File: tb/tb_gps_ca_multi_tss.sv
// Directed bench for gps_ca_multi_tss; expected chips are the published first-ten-chip octal codes.
module tb_gps_ca_multi_tss;

  localparam int NUM_CH = 4;
  localparam int KW     = 2;
  localparam logic [63:0]  KW0     = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0]  KW1     = 64'h0123_4567_89AB_CDEF;
  localparam logic [127:0] KEY_VAL = {KW1, KW0};

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [63:0]         key_word = '0;
  logic                key_valid = 1'b0;
  logic                key_ready;
  logic                key_clear = 1'b0;
  logic [1:0]          key_status;
  logic [6*NUM_CH-1:0] sv_num = '0;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic                chip_en = 1'b0;
  logic [NUM_CH-1:0]   ca_chip;
  logic                chip_valid;
  logic [9:0]          chip_idx;
  logic                epoch;
  logic                busy;

  int checks = 0;
  int errors = 0;

  gps_ca_multi_tss #(
    .NUM_CH(NUM_CH), .KEY_WORDS(KW), .KEY(KEY_VAL), .LOCK_MASK(6'h15)
  ) dut (
    .sys_clk_50(clk), .sync_rst_in(rst),
    .key_word(key_word), .key_valid(key_valid), .key_ready(key_ready),
    .key_clear(key_clear), .key_status(key_status),
    .sv_num(sv_num), .start(start), .stop(stop), .chip_en(chip_en),
    .ca_chip(ca_chip), .chip_valid(chip_valid), .chip_idx(chip_idx),
    .epoch(epoch), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (key_status !== 2'b00 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_key: status %b ready %b, expected 00 1", key_status, key_ready);
    end
    checks++;
    if (ca_chip !== 4'h0 || chip_valid !== 1'b0 || chip_idx !== 10'd0 || epoch !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_seq: ca %b valid %b idx %0d epoch %b busy %b, expected all zero",
               ca_chip, chip_valid, chip_idx, epoch, busy);
    end
    $display("reset: status %b ready %b busy %b", key_status, key_ready, busy);
  endtask

  task automatic test_unlock();
    key_valid = 1'b1;
    key_word  = KW0;
    tick();
    checks++;
    if (key_status !== 2'b01 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL unlock_word0: status %b ready %b, expected 01 1", key_status, key_ready);
    end
    key_word = KW1;
    tick();
    key_valid = 1'b0;
    checks++;
    if (key_status !== 2'b10 || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL unlock_done: status %b ready %b, expected 10 0", key_status, key_ready);
    end
    $display("unlock: status %b", key_status);
  endtask

  task automatic test_prn_unlocked();
    logic [9:0] e [4];
    logic [3:0] expv;
    e[0] = 10'o1440; e[1] = 10'o1620; e[2] = 10'o1710; e[3] = 10'o1712;
    sv_num = {6'd32, 6'd3, 6'd2, 6'd1};
    start = 1'b1;
    tick();
    start   = 1'b0;
    chip_en = 1'b1;
    checks++;
    if (busy !== 1'b1 || chip_valid !== 1'b0) begin
      errors++;
      $display("FAIL prn_start: busy %b valid %b, expected 1 0", busy, chip_valid);
    end
    expv = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      for (int c = 0; c < 4; c++) expv[c] = e[c][9-k];
      checks++;
      if (ca_chip !== expv || chip_idx !== 10'(k) || chip_valid !== 1'b1) begin
        errors++;
        $display("FAIL prn_chip%0d: ca %b idx %0d valid %b, expected %b %0d 1", k, ca_chip, chip_idx, chip_valid, expv, k);
      end
      $display("prn chip %0d: ca %b idx %0d", k, ca_chip, chip_idx);
    end
    chip_en = 1'b0;
    tick();
    checks++;
    if (chip_valid !== 1'b0 || chip_idx !== 10'd9 || ca_chip !== expv) begin
      errors++;
      $display("FAIL prn_hold: valid %b idx %0d ca %b, expected 0 9 %b", chip_valid, chip_idx, ca_chip, expv);
    end
  endtask

  task automatic test_locked();
    logic [9:0] e [4];
    logic [3:0] expv;
    e[0] = 10'o1715; e[1] = 10'o0000; e[2] = 10'o1063; e[3] = 10'o0000;
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    checks++;
    if (key_status !== 2'b00) begin
      errors++;
      $display("FAIL locked_clear: status %b, expected 00", key_status);
    end
    sv_num = {6'h15, 6'd2, 6'h2A, 6'd1};
    start = 1'b1;
    tick();
    start   = 1'b0;
    chip_en = 1'b1;
    expv = '0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (k < 10) begin
        for (int c = 0; c < 4; c++) expv[c] = e[c][9-k];
        checks++;
        if (ca_chip !== expv || chip_idx !== 10'(k)) begin
          errors++;
          $display("FAIL locked_chip%0d: ca %b idx %0d, expected %b %0d", k, ca_chip, chip_idx, expv, k);
        end
        $display("locked chip %0d: ca %b", k, ca_chip);
      end else begin
        checks++;
        if (ca_chip[1] !== 1'b0 || ca_chip[3] !== 1'b0) begin
          errors++;
          $display("FAIL locked_illegal%0d: ch1 %b ch3 %b, expected 0 0", k, ca_chip[1], ca_chip[3]);
        end
      end
    end
    chip_en = 1'b0;
    stop    = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || chip_valid !== 1'b0) begin
      errors++;
      $display("FAIL locked_stop: busy %b valid %b, expected 0 0", busy, chip_valid);
    end
  endtask

  task automatic test_wrong_key();
    key_valid = 1'b1;
    key_word  = KW1;
    tick();
    checks++;
    if (key_status !== 2'b01) begin
      errors++;
      $display("FAIL wrong_word0: status %b, expected 01", key_status);
    end
    key_word = KW0;
    tick();
    checks++;
    if (key_status !== 2'b11 || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL wrong_error: status %b ready %b, expected 11 0", key_status, key_ready);
    end
    key_word = KW0;
    tick();
    key_word = KW1;
    tick();
    checks++;
    if (key_status !== 2'b11) begin
      errors++;
      $display("FAIL wrong_sticky: status %b, expected 11", key_status);
    end
    $display("wrong key: status %b", key_status);
    key_clear = 1'b1;
    key_word  = KW0;
    #1;
    checks++;
    if (key_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_ready: ready %b, expected 0", key_ready);
    end
    tick();
    checks++;
    if (key_status !== 2'b00) begin
      errors++;
      $display("FAIL clear_from_error: status %b, expected 00", key_status);
    end
    tick();
    checks++;
    if (key_status !== 2'b00) begin
      errors++;
      $display("FAIL clear_beats_valid: status %b, expected 00", key_status);
    end
    key_clear = 1'b0;
    key_valid = 1'b0;
    test_unlock();
  endtask

  task automatic test_strobe();
    sv_num = {6'd0, 6'd0, 6'd0, 6'd1};
    start = 1'b1;
    tick();
    start   = 1'b0;
    chip_en = 1'b1;
    tick();
    chip_en = 1'b0;
    checks++;
    if (chip_valid !== 1'b1 || chip_idx !== 10'd0 || ca_chip[0] !== 1'b1) begin
      errors++;
      $display("FAIL strobe_first: valid %b idx %0d ca0 %b, expected 1 0 1", chip_valid, chip_idx, ca_chip[0]);
    end
    tick();
    checks++;
    if (chip_valid !== 1'b0 || chip_idx !== 10'd0 || ca_chip[0] !== 1'b1) begin
      errors++;
      $display("FAIL strobe_gap: valid %b idx %0d ca0 %b, expected 0 0 1", chip_valid, chip_idx, ca_chip[0]);
    end
    chip_en = 1'b1;
    tick();
    chip_en = 1'b0;
    checks++;
    if (chip_valid !== 1'b1 || chip_idx !== 10'd1 || ca_chip[0] !== 1'b1) begin
      errors++;
      $display("FAIL strobe_second: valid %b idx %0d ca0 %b, expected 1 1 1", chip_valid, chip_idx, ca_chip[0]);
    end
    stop = 1'b1;
    tick();
    stop    = 1'b0;
    chip_en = 1'b1;
    tick();
    chip_en = 1'b0;
    checks++;
    if (chip_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL strobe_idle: valid %b busy %b, expected 0 0", chip_valid, busy);
    end
    $display("strobe: idle valid %b busy %b", chip_valid, busy);
  endtask

  task automatic test_wrap();
    sv_num = {6'd0, 6'd0, 6'd0, 6'd1};
    start = 1'b1;
    tick();
    start   = 1'b0;
    chip_en = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      tick();
      checks++;
      if (chip_idx !== 10'(k % 1023) || epoch !== (k == 1022) || chip_valid !== 1'b1) begin
        errors++;
        $display("FAIL wrap_chip%0d: idx %0d epoch %b valid %b, expected %0d %b 1",
                 k, chip_idx, epoch, chip_valid, k % 1023, (k == 1022));
      end
    end
    checks++;
    if (ca_chip[0] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_next_chip: ca0 %b, expected 1", ca_chip[0]);
    end
    $display("wrap: idx %0d ca0 %b after 1024 chips", chip_idx, ca_chip[0]);
    chip_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    tick();
    start   = 1'b0;
    chip_en = 1'b1;
    repeat (501) tick();
    checks++;
    if (chip_idx !== 10'd500) begin
      errors++;
      $display("FAIL restart_pre: idx %0d, expected 500", chip_idx);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (chip_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_cycle: valid %b busy %b, expected 0 1", chip_valid, busy);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (chip_idx !== 10'(k) || ca_chip[0] !== (k < 2) || chip_valid !== 1'b1) begin
        errors++;
        $display("FAIL restart_chip%0d: idx %0d ca0 %b, expected %0d %b", k, chip_idx, ca_chip[0], k, (k < 2));
      end
      $display("restart chip %0d: idx %0d ca0 %b", k, chip_idx, ca_chip[0]);
    end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (busy !== 1'b0 || chip_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_stop: busy %b valid %b, expected 0 0", busy, chip_valid);
    end
    chip_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start   = 1'b0;
    chip_en = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    chip_en = 1'b0;
    checks++;
    if (ca_chip !== 4'h0 || chip_valid !== 1'b0 || chip_idx !== 10'd0 || epoch !== 1'b0 ||
        busy !== 1'b0 || key_status !== 2'b00 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_run: ca %b valid %b idx %0d epoch %b busy %b status %b ready %b",
               ca_chip, chip_valid, chip_idx, epoch, busy, key_status, key_ready);
    end
    key_valid = 1'b1;
    key_word  = KW0;
    tick();
    key_valid = 1'b0;
    checks++;
    if (key_status !== 2'b01) begin
      errors++;
      $display("FAIL reset_load_pre: status %b, expected 01", key_status);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (key_status !== 2'b00 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_load: status %b ready %b, expected 00 1", key_status, key_ready);
    end
    $display("reset mid: status %b busy %b", key_status, busy);
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_prn_unlocked();
    test_locked();
    test_wrong_key();
    test_strobe();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
